// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: turns make/break/extended byte sequences into a held-key
// bitmap plus one-cycle press/release events for the 17 game keys.
module ps2_key_tracker #(
    parameter int PREFIX_TIMEOUT = 2_500_000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        BYTE_VALID,
    input  logic [7:0]  BYTE_DATA,
    input  logic        BYTE_ERR,
    output logic [16:0] KEY_HELD,
    output logic        EVENT_VALID,
    output logic [4:0]  EVENT_KEY,
    output logic        EVENT_MAKE
);

    localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    state_t        state, next_state;
    logic [2:0]    skip_cnt, next_skip;
    logic [TW-1:0] tmo_cnt, next_tmo;
    logic [16:0]   next_held;
    logic          next_ev;
    logic [4:0]    next_key;
    logic          next_make;

    logic          do_make, do_break, use_ext, timed_out;
    logic [5:0]    lk;
    logic [16:0]   key_mask;

    // Returns {hit, index}; arrows only match behind E0, letters only without it
    function automatic logic [5:0] lookup(input logic ext, input logic [7:0] code);
        logic [5:0] r;
        r = 6'd0;
        case ({ext, code})
            9'h175: r = {1'b1, 5'd0};
            9'h172: r = {1'b1, 5'd1};
            9'h16B: r = {1'b1, 5'd2};
            9'h174: r = {1'b1, 5'd3};
            9'h01D: r = {1'b1, 5'd4};
            9'h01B: r = {1'b1, 5'd5};
            9'h01C: r = {1'b1, 5'd6};
            9'h023: r = {1'b1, 5'd7};
            9'h035: r = {1'b1, 5'd8};
            9'h033: r = {1'b1, 5'd9};
            9'h034: r = {1'b1, 5'd10};
            9'h03B: r = {1'b1, 5'd11};
            9'h04D: r = {1'b1, 5'd12};
            9'h04C: r = {1'b1, 5'd13};
            9'h04B: r = {1'b1, 5'd14};
            9'h052: r = {1'b1, 5'd15};
            9'h029: r = {1'b1, 5'd16};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        next_state = state;
        next_skip  = skip_cnt;
        next_held  = KEY_HELD;
        next_ev    = 1'b0;
        next_key   = EVENT_KEY;
        next_make  = EVENT_MAKE;
        do_make    = 1'b0;
        do_break   = 1'b0;
        use_ext    = 1'b0;
        timed_out  = (state != IDLE) && (tmo_cnt == TW'(PREFIX_TIMEOUT - 1));

        if (BYTE_VALID && BYTE_ERR) begin
            next_state = IDLE;
            next_skip  = 3'd0;
        end else if (BYTE_VALID) begin
            case (state)
                IDLE: begin
                    case (BYTE_DATA)
                        8'hE0: next_state = EXT;
                        8'hF0: next_state = BRK;
                        8'hE1: begin
                            next_state = SKIP;
                            next_skip  = 3'd7;
                        end
                        8'hAA: next_held = 17'd0;
                        8'hFA, 8'hEE, 8'hFE: ;
                        default: do_make = 1'b1;
                    endcase
                end
                EXT: begin
                    if (BYTE_DATA == 8'hF0) begin
                        next_state = EXT_BRK;
                    end else if (BYTE_DATA != 8'hE0) begin
                        do_make    = 1'b1;
                        use_ext    = 1'b1;
                        next_state = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    next_state = IDLE;
                    use_ext    = (state == EXT_BRK);
                    do_break   = !(BYTE_DATA == 8'hE0 || BYTE_DATA == 8'hF0 || BYTE_DATA == 8'hE1);
                end
                SKIP: begin
                    next_skip = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        next_state = IDLE;
                        next_skip  = 3'd0;
                    end
                end
                default: next_state = IDLE;
            endcase
        end else if (timed_out) begin
            next_state = IDLE;
            next_skip  = 3'd0;
        end

        // Typematic repeats and breaks of unheld keys fall through silently
        lk       = lookup(use_ext, BYTE_DATA);
        key_mask = 17'd1 << lk[4:0];
        if (lk[5] && do_make && ((KEY_HELD & key_mask) == 17'd0)) begin
            next_held = KEY_HELD | key_mask;
            next_ev   = 1'b1;
            next_key  = lk[4:0];
            next_make = 1'b1;
        end else if (lk[5] && do_break && ((KEY_HELD & key_mask) != 17'd0)) begin
            next_held = KEY_HELD & ~key_mask;
            next_ev   = 1'b1;
            next_key  = lk[4:0];
            next_make = 1'b0;
        end

        if (BYTE_VALID || state == IDLE || timed_out)
            next_tmo = '0;
        else
            next_tmo = tmo_cnt + TW'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= IDLE;
            skip_cnt    <= 3'd0;
            tmo_cnt     <= '0;
            KEY_HELD    <= 17'd0;
            EVENT_VALID <= 1'b0;
            EVENT_KEY   <= 5'd0;
            EVENT_MAKE  <= 1'b0;
        end else begin
            state       <= next_state;
            skip_cnt    <= next_skip;
            tmo_cnt     <= next_tmo;
            KEY_HELD    <= next_held;
            EVENT_VALID <= next_ev;
            EVENT_KEY   <= next_key;
            EVENT_MAKE  <= next_make;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scan-code sequences followed by random byte
// traffic, all compared against a sequence-level key-state model.
module tb_ps2_key_tracker;

    localparam int T = 100;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        BYTE_VALID = 1'b0;
    logic [7:0]  BYTE_DATA = 8'h00;
    logic        BYTE_ERR = 1'b0;
    logic [16:0] KEY_HELD;
    logic        EVENT_VALID;
    logic [4:0]  EVENT_KEY;
    logic        EVENT_MAKE;

    int checks = 0;
    int failures = 0;

    logic [7:0] codes [17] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                               8'h35, 8'h33, 8'h34, 8'h3B, 8'h4D, 8'h4C, 8'h4B, 8'h52, 8'h29};

    // Model: held set, last event, and the partially received prefix
    bit [16:0] m_held;
    bit        m_ev;
    bit [4:0]  m_key;
    bit        m_make;
    bit        m_ext, m_brk;
    int        m_skip;
    longint    cyc = 0;
    longint    last_cyc = 0;

    ps2_key_tracker #(.PREFIX_TIMEOUT(T)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_DATA  (BYTE_DATA),
        .BYTE_ERR   (BYTE_ERR),
        .KEY_HELD   (KEY_HELD),
        .EVENT_VALID(EVENT_VALID),
        .EVENT_KEY  (EVENT_KEY),
        .EVENT_MAKE (EVENT_MAKE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int keyIndex(input logic [7:0] code, input bit ext);
        for (int i = 0; i < 17; i++)
            if (codes[i] == code && ((i < 4) == ext)) return i;
        return -1;
    endfunction

    task automatic modelReset();
        m_held = '0; m_ev = 0; m_key = '0; m_make = 0;
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic modelByte(input logic [7:0] d, input bit err);
        int idx;
        m_ev = 0;
        if ((m_ext || m_brk || m_skip > 0) && (cyc - last_cyc > T)) begin
            m_ext = 0; m_brk = 0; m_skip = 0;
        end
        last_cyc = cyc;
        if (err) begin
            m_ext = 0; m_brk = 0; m_skip = 0;
            return;
        end
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        if (m_brk) begin
            if (!(d == 8'hE0 || d == 8'hF0 || d == 8'hE1)) begin
                idx = keyIndex(d, m_ext);
                if (idx >= 0 && m_held[idx]) begin
                    m_held[idx] = 0; m_ev = 1; m_key = 5'(idx); m_make = 0;
                end
            end
            m_ext = 0; m_brk = 0;
            return;
        end
        if (d == 8'hF0) begin
            m_brk = 1;
            return;
        end
        if (d == 8'hE0) begin
            m_ext = 1;
            return;
        end
        if (!m_ext && d == 8'hE1) begin
            m_skip = 7;
            return;
        end
        if (!m_ext && d == 8'hAA) begin
            m_held = '0;
            return;
        end
        if (!m_ext && (d == 8'hFA || d == 8'hEE || d == 8'hFE)) return;
        idx = keyIndex(d, m_ext);
        if (idx >= 0 && !m_held[idx]) begin
            m_held[idx] = 1; m_ev = 1; m_key = 5'(idx); m_make = 1;
        end
        m_ext = 0;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (KEY_HELD === m_held) else begin
            failures++;
            $error("[TB] FAIL %s key_held observed=%h expected=%h", tag, KEY_HELD, m_held);
        end
        checks++;
        assert (EVENT_VALID === m_ev) else begin
            failures++;
            $error("[TB] FAIL %s event_valid observed=%b expected=%b", tag, EVENT_VALID, m_ev);
        end
        checks++;
        assert (EVENT_KEY === m_key) else begin
            failures++;
            $error("[TB] FAIL %s event_key observed=%0d expected=%0d", tag, EVENT_KEY, m_key);
        end
        checks++;
        assert (EVENT_MAKE === m_make) else begin
            failures++;
            $error("[TB] FAIL %s event_make observed=%b expected=%b", tag, EVENT_MAKE, m_make);
        end
    endtask

    task automatic checkValue(input string tag, input logic [16:0] observed, input logic [16:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit err, input string tag);
        BYTE_VALID = 1'b1;
        BYTE_DATA  = d;
        BYTE_ERR   = err;
        modelByte(d, err);
        @(negedge CLOCK_50);
        cyc++;
        BYTE_VALID = 1'b0;
        BYTE_ERR   = 1'b0;
        checkOutput(tag);
    endtask

    task automatic idleCycles(input int n, input string tag);
        repeat (n) begin
            @(negedge CLOCK_50);
            cyc++;
            m_ev = 0;
            checkOutput(tag);
        end
    endtask

    function automatic logic [7:0] randByte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55) return codes[$urandom_range(0, 16)];
        if (r < 65) return 8'hE0;
        if (r < 77) return 8'hF0;
        if (r < 80) return 8'hE1;
        if (r < 82) return 8'hAA;
        if (r < 85) return (r == 83) ? 8'hFA : ((r == 84) ? 8'hEE : 8'hFE);
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        modelReset();
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        RESET = 1'b0;
        cyc = 0;
        checkOutput("reset");

        applyStimulus(8'h1D, 0, "w_make");
        checkValue("w_held_bit", KEY_HELD, 17'h00010);
        applyStimulus(8'hF0, 0, "w_f0");
        applyStimulus(8'h1D, 0, "w_break");
        checkValue("w_released", KEY_HELD, 17'h00000);

        applyStimulus(8'hE0, 0, "up_e0");
        applyStimulus(8'h75, 0, "up_make");
        applyStimulus(8'h75, 0, "keypad8");
        applyStimulus(8'hE0, 0, "up_e0b");
        applyStimulus(8'hF0, 0, "up_f0");
        applyStimulus(8'h75, 0, "up_break");

        applyStimulus(8'h1D, 0, "tm_make");
        applyStimulus(8'h1D, 0, "tm_rep1");
        applyStimulus(8'h1D, 0, "tm_rep2");
        applyStimulus(8'hE0, 0, "right_e0");
        applyStimulus(8'h74, 0, "right_make");
        applyStimulus(8'hF0, 0, "w_f0b");
        applyStimulus(8'h1D, 0, "w_break2");
        checkValue("multi_final", KEY_HELD, 17'h00008);
        applyStimulus(8'hE0, 0, "right_e0b");
        applyStimulus(8'hF0, 0, "right_f0");
        applyStimulus(8'h74, 0, "right_break");

        applyStimulus(8'hF0, 1, "err_f0");
        applyStimulus(8'h29, 0, "space_make");
        applyStimulus(8'hF0, 0, "prot_f0");
        applyStimulus(8'hE0, 0, "prot_e0");
        applyStimulus(8'h1B, 0, "s_after_prot");

        applyStimulus(8'h1C, 0, "a_make");
        foreach (codes[i]) if (i == 0) begin end
        begin
            logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            foreach (pause_seq[i]) applyStimulus(pause_seq[i], 0, "pause");
        end
        checkValue("pause_kept_a", KEY_HELD & 17'h00040, 17'h00040);
        applyStimulus(8'hAA, 0, "bat");
        checkValue("bat_clear", KEY_HELD, 17'h00000);

        applyStimulus(8'hE0, 0, "tmo_e0");
        idleCycles(T, "tmo_wait");
        applyStimulus(8'h75, 0, "tmo_bare75");
        applyStimulus(8'hE0, 0, "edge_e0");
        idleCycles(T - 1, "edge_wait");
        applyStimulus(8'h75, 0, "edge_up_make");
        applyStimulus(8'hE0, 0, "edge_e0b");
        applyStimulus(8'hF0, 0, "edge_f0");
        idleCycles(T / 2, "edge_wait2");
        applyStimulus(8'h75, 0, "edge_up_break");

        for (int n = 0; n < 600; n++) begin
            int g;
            applyStimulus(randByte(), ($urandom_range(0, 19) == 0), "random");
            g = $urandom_range(0, 9);
            if (g == 0) idleCycles($urandom_range(T - 2, T + 30), "rand_long_gap");
            else if (g < 3) idleCycles($urandom_range(1, 3), "rand_gap");
        end

        applyStimulus(8'h29, 0, "pre_reset_space");
        RESET      = 1'b1;
        BYTE_VALID = 1'b1;
        BYTE_DATA  = 8'h1D;
        @(negedge CLOCK_50);
        cyc++;
        RESET      = 1'b0;
        BYTE_VALID = 1'b0;
        modelReset();
        checkOutput("reset_with_byte");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
